// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream helpers.
// Holds the state type of the burst scheduler that feeds the strided splitter.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        XFER,
        DONE
    } split_sched_state_t;

endpackage

// File: rtl/hwpe_stream_rr_pick.sv
// Combinational round-robin picker: the first set request at or after a pointer,
// wrapping modulo N. Kept generic so the other stream arbiters can reuse it.
module hwpe_stream_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    localparam logic [IDX_W:0] NW = (IDX_W+1)'(N);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Rotate so that bit 0 is the pointer position; the doubled copy handles the wrap.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx   = (w_sum >= NW) ? IDX_W'(w_sum - NW) : IDX_W'(w_sum);
    assign o_valid = |i_req;

endmodule

// File: rtl/hwpe_stream_split_sched.sv
// Burst scheduler sharing one strided-split datapath between several producer streams:
// whole bursts are granted round-robin so interleaved lanes never mix producers.
module hwpe_stream_split_sched
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_IN_STREAMS = 2,
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         clear_i,
    input  logic                                         start_i,
    input  logic [NB_IN_STREAMS-1:0][CNT_WIDTH-1:0]      len_i,
    input  logic [NB_IN_STREAMS-1:0][DATA_WIDTH-1:0]     push_data_i,
    input  logic [NB_IN_STREAMS-1:0][DATA_WIDTH/8-1:0]   push_strb_i,
    input  logic [NB_IN_STREAMS-1:0]                     push_valid_i,
    output logic [NB_IN_STREAMS-1:0]                     push_ready_o,
    output logic [DATA_WIDTH-1:0]                        pop_data_o,
    output logic [DATA_WIDTH/8-1:0]                      pop_strb_o,
    output logic                                         pop_valid_o,
    input  logic                                         pop_ready_i,
    output logic [NB_IN_STREAMS-1:0]                     grant_o,
    output logic                                         busy_o,
    output logic                                         done_o
);

    localparam int unsigned IDX_W = $clog2(NB_IN_STREAMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_IN_STREAMS - 1);
    localparam logic [NB_IN_STREAMS-1:0] ONE_HOT0 = {{(NB_IN_STREAMS-1){1'b0}}, 1'b1};

    split_sched_state_t                          r_state;
    logic [NB_IN_STREAMS-1:0][CNT_WIDTH-1:0]     r_len;
    logic [NB_IN_STREAMS-1:0]                    r_pend;
    logic [NB_IN_STREAMS-1:0]                    r_grant;
    logic [IDX_W-1:0]                            r_ptr;
    logic [IDX_W-1:0]                            r_sel;
    logic [CNT_WIDTH-1:0]                        r_cnt;
    logic                                        r_busy;
    logic                                        r_done;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_xfer;
    logic             w_hs;
    logic             w_last;

    hwpe_stream_rr_pick #(
        .N     (NB_IN_STREAMS),
        .IDX_W (IDX_W)
    ) i_pick (
        .i_req   (r_pend),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_xfer = (r_state == XFER);
    assign w_hs   = w_xfer && push_valid_i[r_sel] && pop_ready_i;
    assign w_last = (r_cnt == r_len[r_sel] - CNT_WIDTH'(1));

    // Zero-latency pass-through of the burst owner; everyone else is held off.
    always_comb begin
        pop_data_o   = '0;
        pop_strb_o   = '0;
        pop_valid_o  = 1'b0;
        push_ready_o = '0;
        if (w_xfer) begin
            pop_data_o          = push_data_i[r_sel];
            pop_strb_o          = push_strb_i[r_sel];
            pop_valid_o         = push_valid_i[r_sel];
            push_ready_o[r_sel] = pop_ready_i;
        end
    end

    // Lengths are pure data: only captured on an accepted start, never cleared.
    always_ff @(posedge clk_i) begin
        if (r_state == IDLE && start_i) begin
            r_len <= len_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i < NB_IN_STREAMS; i++) begin
                            r_pend[i] <= (len_i[i] != '0);
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    if (w_pick_valid) begin
                        r_sel   <= w_pick_idx;
                        r_cnt   <= '0;
                        r_grant <= ONE_HOT0 << w_pick_idx;
                        r_state <= XFER;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                XFER: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                        if (w_last) begin
                            r_pend[r_sel] <= 1'b0;
                            r_ptr         <= (r_sel == LAST_IDX) ? '0 : r_sel + IDX_W'(1);
                            r_grant       <= '0;
                            r_state       <= ARB;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant_o = r_grant;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_hwpe_stream_split_sched.sv
// Self-checking bench for hwpe_stream_split_sched: directed and randomized jobs
// compared against a burst-order/timing model derived from the round-robin rules.
module tb_hwpe_stream_split_sched;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int SW = DW / 8;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     clear_i;
    logic                     start_i;
    logic [N-1:0][CW-1:0]     len_i;
    logic [N-1:0][DW-1:0]     push_data_i;
    logic [N-1:0][SW-1:0]     push_strb_i;
    logic [N-1:0]             push_valid_i;
    logic [N-1:0]             push_ready_o;
    logic [DW-1:0]            pop_data_o;
    logic [SW-1:0]            pop_strb_o;
    logic                     pop_valid_o;
    logic                     pop_ready_i;
    logic [N-1:0]             grant_o;
    logic                     busy_o;
    logic                     done_o;

    hwpe_stream_split_sched #(
        .NB_IN_STREAMS (N),
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .push_data_i  (push_data_i),
        .push_strb_i  (push_strb_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .pop_data_o   (pop_data_o),
        .pop_strb_o   (pop_strb_o),
        .pop_valid_o  (pop_valid_o),
        .pop_ready_i  (pop_ready_i),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int c0 = 0;
    int job_id = 0;
    int exp_ptr = 0;
    int k [N];
    int jlen [N];
    int ready_mode = 0;
    int valid_mode = 0;
    int stall_left = 0;
    bit stall_en = 0;
    bit stall_used = 0;
    bit logging = 0;
    bit inv_on = 0;
    bit chk_rst = 0;
    string rst_tag = "por";

    logic [DW-1:0] q_data[$];
    logic [SW-1:0] q_strb[$];
    logic [N-1:0]  q_gnt[$];
    int            q_cyc[$];
    int            done_cyc[$];
    logic [N-1:0]  g_log[$];
    int            g_cyc[$];
    int            busy_first;
    int            busy_cnt;
    int            bad_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int r, input int j, input int b);
        return {4'(r), 12'(j), 16'(b)};
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int r, input int b);
        return SW'((b * 3 + r * 5 + 1) % 16);
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_pop_valid"}, 64'(pop_valid_o), 0);
        chk({tag, "_pop_data"}, 64'(pop_data_o), 0);
        chk({tag, "_pop_strb"}, 64'(pop_strb_o), 0);
        chk({tag, "_push_ready"}, 64'(push_ready_o), 0);
        chk({tag, "_grant"}, 64'(grant_o), 0);
        chk({tag, "_busy"}, 64'(busy_o), 0);
        chk({tag, "_done"}, 64'(done_o), 0);
    endtask

    task automatic drive();
        case (ready_mode)
            0:       pop_ready_i = 1'b1;
            1:       pop_ready_i = ((cyc_n - c0) % 2 == 0);
            default: pop_ready_i = 1'($urandom_range(0, 1));
        endcase
        for (int r = 0; r < N; r++) begin
            logic v;
            v = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (r == 0 && stall_en && !stall_used && k[0] == 2) begin
                stall_left = 2;
                stall_used = 1;
            end
            if (r == 0 && stall_left > 0) begin
                v = 1'b0;
                stall_left--;
            end
            push_valid_i[r] = v;
            push_data_i[r]  = beat_data(r, job_id, k[r]);
            push_strb_i[r]  = beat_strb(r, k[r]);
        end
    endtask

    // One clock: observe at the falling edge, then drive just after the rising edge.
    task automatic tick();
        @(negedge clk_i);
        if (chk_rst) begin
            check_idle(rst_tag);
            chk_rst = 0;
        end
        if (inv_on) begin
            chk("gnt_onehot", 64'($countones(grant_o) <= 1), 1);
            chk("ready_outside_gnt", 64'(push_ready_o & ~grant_o), 0);
            chk("valid_without_gnt", 64'(pop_valid_o && (grant_o == '0)), 0);
        end
        if (logging) begin
            if (pop_valid_o && pop_ready_i) begin
                q_data.push_back(pop_data_o);
                q_strb.push_back(pop_strb_o);
                q_gnt.push_back(grant_o);
                q_cyc.push_back(cyc_n);
            end
            if (done_o) done_cyc.push_back(cyc_n);
            if (busy_o) begin
                if (busy_cnt == 0) busy_first = cyc_n;
                busy_cnt++;
            end
            g_log.push_back(grant_o);
            g_cyc.push_back(cyc_n);
            for (int r = 0; r < N; r++) begin
                if (push_ready_o[r] && jlen[r] == 0) bad_ready++;
            end
        end
        for (int r = 0; r < N; r++) begin
            if (push_valid_i[r] && push_ready_o[r]) k[r]++;
        end
        @(posedge clk_i);
        cyc_n++;
        #1;
        drive();
    endtask

    task automatic new_job(input int l0, input int l1, input int rm, input int vm, input bit stall);
        job_id++;
        jlen[0] = l0;
        jlen[1] = l1;
        k[0] = 0;
        k[1] = 0;
        ready_mode = rm;
        valid_mode = vm;
        stall_en = stall;
        stall_used = 0;
        stall_left = 0;
        q_data.delete();
        q_strb.delete();
        q_gnt.delete();
        q_cyc.delete();
        done_cyc.delete();
        g_log.delete();
        g_cyc.delete();
        busy_first = -1;
        busy_cnt = 0;
        bad_ready = 0;
        c0 = cyc_n;
        drive();
        len_i[0] = CW'(l0);
        len_i[1] = CW'(l1);
        start_i = 1'b1;
        logging = 1;
    endtask

    task automatic run_job(input int l0, input int l1, input int rm, input int vm,
                           input bit timing, input bit stall, input bit restart);
        logic [DW-1:0] e_data[$];
        logic [SW-1:0] e_strb[$];
        logic [N-1:0]  e_gnt[$];
        int            e_cyc[$];
        int            order[$];
        int            t;
        int            n;
        int            nb;
        int            stall_bad;

        new_job(l0, l1, rm, vm, stall);
        // Reference: bursts in cyclic order from the pointer, one ARB cycle before each.
        for (int i = 0; i < N; i++) begin
            int r;
            r = (exp_ptr + i) % N;
            if (jlen[r] != 0) order.push_back(r);
        end
        t = 2;
        foreach (order[o]) begin
            for (int b = 0; b < jlen[order[o]]; b++) begin
                e_data.push_back(beat_data(order[o], job_id, b));
                e_strb.push_back(beat_strb(order[o], b));
                e_gnt.push_back(N'(1) << order[o]);
                e_cyc.push_back(t + b);
            end
            t += jlen[order[o]] + 1;
        end

        tick();
        start_i = 1'b0;
        len_i[0] = CW'($urandom);
        len_i[1] = CW'($urandom);
        n = 0;
        while (done_cyc.size() == 0 && n < 4000) begin
            if (restart && cyc_n == c0 + 3) begin
                start_i = 1'b1;
                len_i[0] = CW'(7);
                len_i[1] = CW'(7);
            end
            tick();
            start_i = 1'b0;
            n++;
        end
        chk("job_done_seen", 64'(done_cyc.size() != 0), 1);
        repeat (4) tick();
        logging = 0;

        chk("job_beats", 64'(q_data.size()), 64'(e_data.size()));
        nb = (q_data.size() < e_data.size()) ? q_data.size() : e_data.size();
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("beat%0d_data", i), 64'(q_data[i]), 64'(e_data[i]));
            chk($sformatf("beat%0d_strb", i), 64'(q_strb[i]), 64'(e_strb[i]));
            chk($sformatf("beat%0d_grant", i), 64'(q_gnt[i]), 64'(e_gnt[i]));
            if (timing) chk($sformatf("beat%0d_cycle", i), 64'(q_cyc[i]), 64'(c0 + e_cyc[i]));
        end
        chk("job_done_count", 64'(done_cyc.size()), 1);
        if (done_cyc.size() > 0) begin
            if (timing) chk("job_done_cycle", 64'(done_cyc[0]), 64'(c0 + t));
            chk("busy_first", 64'(busy_first), 64'(c0 + 1));
            chk("busy_len", 64'(busy_cnt), 64'(done_cyc[0] - c0));
        end
        chk("idle_req_ready", 64'(bad_ready), 0);
        if (stall && q_cyc.size() > 0) begin
            stall_bad = 0;
            foreach (g_log[i]) begin
                if (g_cyc[i] >= c0 + 2 && g_cyc[i] <= q_cyc[q_cyc.size()-1] && g_log[i] != 2'b01)
                    stall_bad++;
            end
            chk("stall_grant_hold", 64'(stall_bad), 0);
        end
        if (order.size() > 0) exp_ptr = (order[order.size()-1] + 1) % N;
    endtask

    task automatic mid_abort(input bit use_clear, input string tag);
        int n;
        new_job(5, 5, 0, 0, 0);
        tick();
        start_i = 1'b0;
        n = 0;
        while (q_data.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_two_beats"}, 64'(q_data.size()), 2);
        if (q_gnt.size() > 0) chk({tag, "_first_owner"}, 64'(q_gnt[0]), 64'(N'(1) << exp_ptr));
        if (use_clear) clear_i = 1'b1;
        else           rst_ni  = 1'b0;
        tick();
        rst_ni  = 1'b1;
        clear_i = 1'b0;
        rst_tag = tag;
        chk_rst = 1;
        done_cyc.delete();
        tick();
        repeat (3) tick();
        chk({tag, "_no_done"}, 64'(done_cyc.size()), 0);
        logging = 0;
        exp_ptr = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        start_i = 1'b0;
        len_i   = '0;
        k[0] = 0;
        k[1] = 0;
        jlen[0] = 0;
        jlen[1] = 0;
        drive();
        repeat (2) tick();
        rst_tag = "por";
        chk_rst = 1;
        tick();
        rst_ni = 1'b1;
        inv_on = 1;
        tick();

        run_job(0, 3, 0, 0, 1, 0, 0);
        run_job(2, 2, 0, 0, 1, 0, 0);
        run_job(1, 1, 0, 0, 1, 0, 0);
        run_job(4, 0, 1, 0, 0, 1, 0);
        run_job(0, 0, 0, 0, 1, 0, 0);
        run_job(3, 2, 0, 0, 1, 0, 1);

        mid_abort(0, "rst");
        run_job(1, 1, 0, 0, 1, 0, 0);
        run_job(2, 0, 0, 0, 1, 0, 0);
        mid_abort(1, "clr");
        run_job(1, 1, 0, 0, 1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            int rm;
            int vm;
            rm = $urandom_range(0, 2);
            vm = $urandom_range(0, 1);
            run_job($urandom_range(0, 6), $urandom_range(0, 6), rm, vm, (rm == 0 && vm == 0), 0, 0);
        end
        run_job(40, 17, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
